// File: rtl/button_event_controller.sv
// Multi-channel active-low push-button controller.
// Each channel runs an early-response debounce FSM clocked by a shared
// prescaler tick; press/release edges are parked in one pending slot per
// channel and a round-robin arbiter serializes them onto a valid/ready
// event stream.
module button_event_controller #(
  parameter int N        = 4,
  parameter int IDXW     = 2,
  parameter int TICK_DIV = 100000,
  parameter int DB_TICKS = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    sw_low,
  output logic [N-1:0]    db,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [IDXW-1:0] evt_idx,
  output logic            evt_press,
  output logic            overflow,
  input  logic            overflow_clr
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DB_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT1 = 2'd1,
    S_ONE   = 2'd2,
    S_WAIT0 = 2'd3
  } state_t;

  // ---- Stage p0/p1: two-flop synchronizer, idles at 1 (released) ----
  logic [N-1:0] sync_p0;
  logic [N-1:0] sync_p1;
  logic [N-1:0] p;

  // Bring the asynchronous switch levels into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= sw_low;
      sync_p1 <= sync_p0;
    end
  end

  // Active-high "pressed" view of the synchronized levels
  assign p = ~sync_p1;

  // ---- Shared debounce prescaler ----
  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Free-running 0..TICK_DIV-1 counter; tick marks the wrap cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // ---- Stage p2: per-channel debounce FSMs ----
  state_t        state     [N];
  state_t        state_nxt [N];
  logic [CW-1:0] cnt       [N];
  logic [CW-1:0] cnt_nxt   [N];
  logic [N-1:0]  raise_evt;
  logic [N-1:0]  raise_press;

  // State register; db is registered from the next state so it never glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        state[i] <= S_IDLE;
        cnt[i]   <= '0;
      end
      db <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
        db[i]    <= (state_nxt[i] == S_WAIT1) || (state_nxt[i] == S_ONE);
      end
    end
  end

  // Next-state logic: act on the first edge, then ignore input for DB_TICKS ticks
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        S_IDLE: begin
          if (p[i]) begin
            state_nxt[i] = S_WAIT1;
            cnt_nxt[i]   = CW'(DB_TICKS);
          end
        end
        S_WAIT1: begin
          if (tick) begin
            cnt_nxt[i] = cnt[i] - CW'(1);
            if (cnt[i] == CW'(1)) begin
              state_nxt[i] = S_ONE;
            end
          end
        end
        S_ONE: begin
          if (!p[i]) begin
            state_nxt[i] = S_WAIT0;
            cnt_nxt[i]   = CW'(DB_TICKS);
          end
        end
        S_WAIT0: begin
          if (tick) begin
            cnt_nxt[i] = cnt[i] - CW'(1);
            if (cnt[i] == CW'(1)) begin
              state_nxt[i] = S_IDLE;
            end
          end
        end
        default: begin
          state_nxt[i] = S_IDLE;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // Event outputs: an edge is raised in the same cycle the FSM accepts it
  always_comb begin
    raise_evt   = '0;
    raise_press = '0;
    for (int i = 0; i < N; i++) begin
      raise_evt[i]   = ((state[i] == S_IDLE) && p[i]) ||
                       ((state[i] == S_ONE) && !p[i]);
      raise_press[i] = (state[i] == S_IDLE);
    end
  end

  // ---- Pending slots and round-robin arbiter ----
  logic [N-1:0]    pend_vld;
  logic [N-1:0]    pend_kind;
  logic [N-1:0]    take;
  logic [N-1:0]    drop;
  logic [IDXW-1:0] rr;
  logic [IDXW-1:0] rr_nxt;
  logic            load;
  logic            hi_vld;
  logic [IDXW-1:0] hi_idx;
  logic            hi_kind;
  logic            lo_vld;
  logic [IDXW-1:0] lo_idx;
  logic            lo_kind;
  logic            grant_vld;
  logic [IDXW-1:0] grant_idx;
  logic            grant_kind;

  // Output register can take a new event when empty or being consumed
  assign load = ~evt_valid | evt_ready;

  // Lowest pending channel at/after rr, else lowest overall (the wrap-around case)
  always_comb begin
    hi_vld  = 1'b0;
    hi_idx  = '0;
    hi_kind = 1'b0;
    lo_vld  = 1'b0;
    lo_idx  = '0;
    lo_kind = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_vld[i]) begin
        lo_vld  = 1'b1;
        lo_idx  = IDXW'(i);
        lo_kind = pend_kind[i];
        if (IDXW'(i) >= rr) begin
          hi_vld  = 1'b1;
          hi_idx  = IDXW'(i);
          hi_kind = pend_kind[i];
        end
      end
    end
    grant_vld  = lo_vld;
    grant_idx  = hi_vld ? hi_idx : lo_idx;
    grant_kind = hi_vld ? hi_kind : lo_kind;
    rr_nxt     = (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + IDXW'(1);
  end

  // Per-slot transfer and drop decisions; a slot emptied this cycle may refill
  always_comb begin
    take = '0;
    drop = '0;
    for (int i = 0; i < N; i++) begin
      take[i] = load && grant_vld && (grant_idx == IDXW'(i));
      drop[i] = raise_evt[i] && pend_vld[i] && !take[i];
    end
  end

  // Pending slot storage: new edge wins over an outgoing one, else the old one stays
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld  <= '0;
      pend_kind <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (raise_evt[i] && (!pend_vld[i] || take[i])) begin
          pend_vld[i]  <= 1'b1;
          pend_kind[i] <= raise_press[i];
        end else if (take[i]) begin
          pend_vld[i] <= 1'b0;
        end
      end
    end
  end

  // ---- Output register ----
  // Event stream register and round-robin pointer; payload holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      evt_press <= 1'b0;
      rr        <= '0;
    end else if (load) begin
      evt_valid <= grant_vld;
      if (grant_vld) begin
        evt_idx   <= grant_idx;
        evt_press <= grant_kind;
        rr        <= rr_nxt;
      end
    end
  end

  // Sticky drop flag; a new drop takes priority over a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (|drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
